// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: pixel-rate enable, h/v counters, coordinate/cell stage A, colour/sync stage B.
// Optional build macro VGA_COLOR_BARS_EN replaces the colour inputs with an 8-bar test pattern.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 4,
    parameter int CNT_W       = 10,
    parameter int COLOR_W     = 4,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COLOR_W-1:0]           red,
    input  logic [COLOR_W-1:0]           green,
    input  logic [COLOR_W-1:0]           blue,
    output logic [COLOR_W-1:0]           Red,
    output logic [COLOR_W-1:0]           Green,
    output logic [COLOR_W-1:0]           Blue,
    output logic                         h_sync,
    output logic                         v_sync,
    output logic [CNT_W-1:0]             px,
    output logic [CNT_W-1:0]             py,
    output logic                         video,
    output logic [CNT_W-CELL_W_LOG2-1:0] cell_col,
    output logic [CNT_W-CELL_H_LOG2-1:0] cell_row,
    output logic [CELL_W_LOG2-1:0]       pos,
    output logic [CELL_H_LOG2-1:0]       rowad,
    output logic                         pix_tick,
    output logic                         frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick;
    logic [CNT_W-1:0]   hc_q, hc_d, vc_q, vc_d;
    logic [CNT_W-1:0]   px_q, px_d, py_q, py_d;
    logic               video_q, video_d;
    logic               fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0] r_src, g_src, b_src;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               hs_in, vs_in;

    // Gated by reset so that CLK_DIV=1 does not tick while reset is held.
    assign tick = (div_q == DIV_LAST) && !reset;

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) div_d = '0;
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (tick) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Stage A: present the counters as coordinates.
    always_comb begin
        px_d    = px_q;
        py_d    = py_q;
        video_d = video_q;
        if (tick) begin
            px_d    = hc_q;
            py_d    = vc_q;
            video_d = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        end
    end

    assign fs_d = tick && (hc_q == '0) && (vc_q == '0);

`ifdef VGA_COLOR_BARS_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    logic [CNT_W-1:0] bar;
    logic             unused_colour;
    assign bar           = px_q / BAR_W;
    assign r_src         = {COLOR_W{bar[2]}};
    assign g_src         = {COLOR_W{bar[1]}};
    assign b_src         = {COLOR_W{bar[0]}};
    assign unused_colour = ^{red, green, blue};
`else
    assign r_src = red;
    assign g_src = green;
    assign b_src = blue;
`endif

    assign hs_in = (px_q >= HS_BEG_C) && (px_q < HS_END_C);
    assign vs_in = (py_q >= VS_BEG_C) && (py_q < VS_END_C);

    // Stage B: colour and sync one pixel behind stage A, derived from stage A state.
    always_comb begin
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (tick) begin
            r_d  = video_q ? r_src : '0;
            g_d  = video_q ? g_src : '0;
            b_d  = video_q ? b_src : '0;
            hs_d = hs_in ? HS_POL : ~HS_POL;
            vs_d = vs_in ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            px_q    <= px_d;
            py_q    <= py_d;
            video_q <= video_d;
            fs_q    <= fs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign px          = px_q;
    assign py          = py_q;
    assign video       = video_q;
    assign cell_col    = px_q[CNT_W-1:CELL_W_LOG2];
    assign cell_row    = py_q[CNT_W-1:CELL_H_LOG2];
    assign pos         = px_q[CELL_W_LOG2-1:0];
    assign rowad       = py_q[CELL_H_LOG2-1:0];
    assign Red         = r_q;
    assign Green       = g_q;
    assign Blue        = b_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign pix_tick    = tick;
    assign frame_start = fs_q;

endmodule
